// File: rtl/counter.sv
// WIDTH-bit up/down counter with asynchronous active-low reset, active-low
// synchronous parallel load, count enable and combinational terminal-count flags.
module counter #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_n,
    input  logic             up_down,
    input  logic             ce,
    input  logic [WIDTH-1:0] data_load,
    output logic [WIDTH-1:0] count_out,
    output logic             max_count,
    output logic             zero
);

    logic [WIDTH-1:0] count_reg;
    logic [WIDTH-1:0] count_next;

    // Load beats counting regardless of ce/up_down; the adders wrap naturally.
    always_comb begin
        count_next = count_reg;
        if (!load_n) begin
            count_next = data_load;
        end else if (ce) begin
            if (up_down) begin
                count_next = count_reg + {{(WIDTH-1){1'b0}}, 1'b1};
            end else begin
                count_next = count_reg - {{(WIDTH-1){1'b0}}, 1'b1};
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_next;
        end
    end

    assign count_out = count_reg;
    assign max_count = &count_reg;
    assign zero      = ~|count_reg;

endmodule

// File: tb/tb_counter.sv
// Self-checking bench for counter: directed scenarios plus a randomised run
// checked against an arithmetic reference model.
module tb_counter;

    localparam int W   = 4;
    localparam int MOD = 1 << W;

    logic         clk;
    logic         rst_n;
    logic         load_n;
    logic         up_down;
    logic         ce;
    logic [W-1:0] data_load;
    logic [W-1:0] count_out;
    logic         max_count;
    logic         zero;

    int n_cmp;
    int n_err;

    counter #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .load_n    (load_n),
        .up_down   (up_down),
        .ce        (ce),
        .data_load (data_load),
        .count_out (count_out),
        .max_count (max_count),
        .zero      (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One active edge; returns at the following falling edge for sampling.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        load_n = 1'b0; data_load = 4'd9; ce = 1'b0; up_down = 1'b1;
        tick();
        load_n = 1'b1; ce = 1'b1; up_down = 1'b1;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (count_out !== 4'd0 || zero !== 1'b1 || max_count !== 1'b0) begin
            n_err++;
            $display("FAIL reset_async: count=%0d zero=%b max=%b required count=0 zero=1 max=0",
                     count_out, zero, max_count);
        end
        tick();
        n_cmp++;
        if (count_out !== 4'd0 || zero !== 1'b1 || max_count !== 1'b0) begin
            n_err++;
            $display("FAIL reset_edge: count=%0d zero=%b max=%b required count=0 zero=1 max=0",
                     count_out, zero, max_count);
        end
        rst_n = 1'b1;
        $display("reset: count=%0d zero=%b max=%b", count_out, zero, max_count);
    endtask

    task automatic test_load_count();
        logic [W-1:0] exp_seq [3];
        exp_seq[0] = 4'd4; exp_seq[1] = 4'd3; exp_seq[2] = 4'd4;
        load_n = 1'b0; data_load = 4'b0100; ce = 1'b0; up_down = 1'b1;
        tick();
        n_cmp++;
        if (count_out !== exp_seq[0]) begin
            n_err++;
            $display("FAIL load: count=%0d required %0d", count_out, exp_seq[0]);
        end
        load_n = 1'b1; ce = 1'b1; up_down = 1'b0;
        tick();
        n_cmp++;
        if (count_out !== exp_seq[1]) begin
            n_err++;
            $display("FAIL count_down: count=%0d required %0d", count_out, exp_seq[1]);
        end
        up_down = 1'b1;
        tick();
        n_cmp++;
        if (count_out !== exp_seq[2]) begin
            n_err++;
            $display("FAIL count_up: count=%0d required %0d", count_out, exp_seq[2]);
        end
        $display("load_count: final count=%0d", count_out);
    endtask

    task automatic test_wrap();
        load_n = 1'b1; ce = 1'b0;
        do_reset();
        ce = 1'b1; up_down = 1'b0;
        tick();
        n_cmp++;
        if (count_out !== 4'hF || max_count !== 1'b1 || zero !== 1'b0) begin
            n_err++;
            $display("FAIL wrap_down: count=%0h max=%b zero=%b required F max=1 zero=0",
                     count_out, max_count, zero);
        end
        up_down = 1'b1;
        tick();
        n_cmp++;
        if (count_out !== 4'h0 || zero !== 1'b1 || max_count !== 1'b0) begin
            n_err++;
            $display("FAIL wrap_up: count=%0h max=%b zero=%b required 0 max=0 zero=1",
                     count_out, max_count, zero);
        end
        ce = 1'b0;
        $display("wrap: count=%0h", count_out);
    endtask

    task automatic test_load_priority();
        load_n = 1'b0; ce = 1'b1; up_down = 1'b1; data_load = 4'h0;
        tick();
        n_cmp++;
        if (count_out !== 4'h0 || zero !== 1'b1 || max_count !== 1'b0) begin
            n_err++;
            $display("FAIL load_prio_zero: count=%0h zero=%b max=%b required 0 zero=1 max=0",
                     count_out, zero, max_count);
        end
        data_load = 4'hF;
        tick();
        n_cmp++;
        if (count_out !== 4'hF || max_count !== 1'b1 || zero !== 1'b0) begin
            n_err++;
            $display("FAIL load_prio_max: count=%0h zero=%b max=%b required F zero=0 max=1",
                     count_out, zero, max_count);
        end
        load_n = 1'b1; ce = 1'b0;
        $display("load_priority: count=%0h", count_out);
    endtask

    task automatic test_hold();
        load_n = 1'b0; data_load = 4'b0010; ce = 1'b0;
        tick();
        load_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            up_down = ~up_down;
            data_load = W'($urandom_range(0, MOD - 1));
            tick();
            n_cmp++;
            if (count_out !== 4'd2) begin
                n_err++;
                $display("FAIL hold[%0d]: count=%0d required 2", i, count_out);
            end
        end
        $display("hold: count=%0d", count_out);
    endtask

    task automatic test_back_to_back_load();
        load_n = 1'b0; ce = 1'b1;
        for (int i = 0; i < 4; i++) begin
            int v;
            v = (i * 5 + 3) % MOD;
            data_load = W'(v);
            up_down = i[0];
            tick();
            n_cmp++;
            if (count_out !== W'(v)) begin
                n_err++;
                $display("FAIL b2b_load[%0d]: count=%0d required %0d", i, count_out, v);
            end
        end
        load_n = 1'b1; ce = 1'b0;
        $display("back_to_back_load: count=%0d", count_out);
    endtask

    // Reference model: plain integer arithmetic modulo 2^W.
    task automatic test_random();
        int model;
        int errs_before;
        model = int'(count_out);
        errs_before = n_err;
        for (int i = 0; i < 200; i++) begin
            rst_n     = ($urandom_range(0, 7) != 0);
            load_n    = ($urandom_range(0, 3) != 0);
            ce        = $urandom_range(0, 1) == 1;
            up_down   = $urandom_range(0, 1) == 1;
            data_load = W'($urandom_range(0, MOD - 1));
            if (!rst_n) model = 0;
            @(posedge clk);
            if (!rst_n)      model = 0;
            else if (!load_n) model = int'(data_load);
            else if (ce && up_down)  model = (model + 1) % MOD;
            else if (ce && !up_down) model = (model + MOD - 1) % MOD;
            @(negedge clk);
            n_cmp++;
            if (count_out !== W'(model) || zero !== (model == 0) ||
                max_count !== (model == MOD - 1)) begin
                n_err++;
                $display("FAIL random[%0d]: count=%0d zero=%b max=%b required count=%0d zero=%b max=%b",
                         i, count_out, zero, max_count, model, model == 0, model == MOD - 1);
            end
        end
        rst_n = 1'b1;
        $display("random: 200 cycles, %0d errors", n_err - errs_before);
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b0; load_n = 1'b1; up_down = 1'b1; ce = 1'b0; data_load = '0;
        tick();
        rst_n = 1'b1;
        test_reset();
        test_load_count();
        test_wrap();
        test_load_priority();
        test_hold();
        test_back_to_back_load();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
